// File: rtl/sevenseg_scan_driver.sv
// Multiplexed N-digit seven-segment scanner; frames are committed only at the scan wrap.
// Define SEVSEG_BLINK_EN to add the wr_blink mask port and the blink counter.
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int DIV_LOG2    = 14,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1,
    parameter int BLINK_LOG2  = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic                      wr_mode,
    input  logic [7*NUM_DIGITS-1:0]   wr_pattern,
    input  logic [4*NUM_DIGITS-1:0]   wr_nibble,
    input  logic [NUM_DIGITS-1:0]     wr_blank,
    input  logic                      wr_lzs,
`ifdef SEVSEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]     wr_blink,
`endif
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     anode_en,
    output logic                      frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF = {7{SEG_ACT_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACT_LOW}};

    if (DIV_LOG2 < 1 || BLINK_LOG2 < 1 || NUM_DIGITS < 1) begin : g_bad_params
        $error("sevenseg_scan_driver: DIV_LOG2, BLINK_LOG2 and NUM_DIGITS must be >= 1");
    end

    typedef struct packed {
        logic                    mode;
        logic [7*NUM_DIGITS-1:0] pattern;
        logic [4*NUM_DIGITS-1:0] nibble;
        logic [NUM_DIGITS-1:0]   blank;
        logic                    lzs;
        logic [NUM_DIGITS-1:0]   blink;
    } frame_t;

    localparam frame_t DASH_FRAME = '{mode: 1'b0, pattern: {NUM_DIGITS{DASH}}, nibble: '0,
                                      blank: '0, lzs: 1'b0, blink: '0};

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'b0111111;
            4'h1: hex_glyph = 7'b0000110;
            4'h2: hex_glyph = 7'b1011011;
            4'h3: hex_glyph = 7'b1001111;
            4'h4: hex_glyph = 7'b1100110;
            4'h5: hex_glyph = 7'b1101101;
            4'h6: hex_glyph = 7'b1111101;
            4'h7: hex_glyph = 7'b0000111;
            4'h8: hex_glyph = 7'b1111111;
            4'h9: hex_glyph = 7'b1101111;
            4'hA: hex_glyph = 7'b1110111;
            4'hB: hex_glyph = 7'b1111100;
            4'hC: hex_glyph = 7'b0111001;
            4'hD: hex_glyph = 7'b1011110;
            4'hE: hex_glyph = 7'b1111001;
            default: hex_glyph = 7'b1110001;
        endcase
    endfunction

    logic [DIV_LOG2-1:0]   presc;
    logic [IDX_W-1:0]      idx, idx_n;
    logic                  tick, wrap, take, commit, pend_full;
    logic                  blink_phase, dark, zero_above;
    frame_t                pend, act, act_n, in_frame;
    logic [NUM_DIGITS-1:0] sup, an_l;
    logic [6:0]            seg_l;

    assign tick     = (presc == '1);
    assign wrap     = tick && (idx == LAST_IDX);
    assign idx_n    = !tick ? idx : (idx == LAST_IDX) ? '0 : idx + 1'b1;
    assign wr_ready = !pend_full;
    assign take     = wr_valid && !pend_full;
    // A frame captured on the wrap tick itself is not yet pending, so it waits a full frame.
    assign commit   = wrap && pend_full;
    assign act_n    = commit ? pend : act;

    always_comb begin
        in_frame.mode    = wr_mode;
        in_frame.pattern = wr_pattern;
        in_frame.nibble  = wr_nibble;
        in_frame.blank   = wr_blank;
        in_frame.lzs     = wr_lzs;
`ifdef SEVSEG_BLINK_EN
        in_frame.blink   = wr_blink;
`else
        in_frame.blink   = '0;
`endif
    end

`ifdef SEVSEG_BLINK_EN
    logic [BLINK_LOG2:0] blink_cnt, blink_cnt_n;
    assign blink_cnt_n = blink_cnt + 1'b1;
    assign blink_phase = blink_cnt_n[BLINK_LOG2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) blink_cnt <= '0;
        else       blink_cnt <= blink_cnt_n;
    end
`else
    assign blink_phase = 1'b0;
`endif

    // Digit j is a suppressed leading zero when nibbles j..top are all zero; digit 0 always shows.
    always_comb begin
        zero_above = 1'b1;
        sup = '0;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            zero_above = zero_above && (act_n.nibble[4*j +: 4] == 4'd0);
            sup[j] = act_n.mode && act_n.lzs && (j != 0) && zero_above;
        end
    end

    always_comb begin
        dark  = act_n.blank[idx_n] || sup[idx_n] || (blink_phase && act_n.blink[idx_n]);
        seg_l = '0;
        an_l  = '0;
        if (!dark) begin
            seg_l = act_n.mode ? hex_glyph(act_n.nibble[4*idx_n +: 4]) : act_n.pattern[7*idx_n +: 7];
            an_l[idx_n] = 1'b1;
        end
    end

    // Outputs are built from next-state index and frame so they land together one cycle after tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc       <= '0;
            idx         <= '0;
            pend_full   <= 1'b0;
            pend        <= DASH_FRAME;
            act         <= DASH_FRAME;
            seg         <= SEG_OFF;
            anode_en    <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            presc       <= presc + 1'b1;
            idx         <= idx_n;
            seg         <= seg_l ^ SEG_OFF;
            anode_en    <= an_l ^ AN_OFF;
            frame_start <= wrap;
            if (commit) begin
                act       <= pend;
                pend_full <= 1'b0;
            end
            if (take) begin
                pend      <= in_frame;
                pend_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with DIV_LOG2=2 (4-clk slots, 16-clk frames), BLINK_LOG2=5.
// Blink scenario runs only when SEVSEG_BLINK_EN is defined.
module tb_sevenseg_scan_driver;

    localparam logic [6:0] DASH_P = 7'b0111111;
    localparam logic [6:0] OFF_P  = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        wr_mode = 1'b0;
    logic [27:0] wr_pattern = '0;
    logic [15:0] wr_nibble = '0;
    logic [3:0]  wr_blank = '0;
    logic        wr_lzs = 1'b0;
`ifdef SEVSEG_BLINK_EN
    logic [3:0]  wr_blink = '0;
`endif
    logic [6:0]  seg;
    logic [3:0]  anode_en;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(
        .NUM_DIGITS(4), .DIV_LOG2(2), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1), .BLINK_LOG2(5)
    ) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_mode(wr_mode), .wr_pattern(wr_pattern), .wr_nibble(wr_nibble),
        .wr_blank(wr_blank), .wr_lzs(wr_lzs),
`ifdef SEVSEG_BLINK_EN
        .wr_blink(wr_blink),
`endif
        .seg(seg), .anode_en(anode_en), .frame_start(frame_start)
    );

    // Stops at the first negedge where frame_start is high (frame position k=0).
    task automatic sync_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_frame(input logic mode, input logic [27:0] pat, input logic [15:0] nib,
                              input logic [3:0] blank, input logic lzs, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (wr_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            wr_mode = mode; wr_pattern = pat; wr_nibble = nib; wr_blank = blank; wr_lzs = lzs;
            wr_valid = 1'b1;
            @(negedge clk);
            wr_valid = 1'b0;
        end
    endtask

    // Samples each digit slot mid-slot over the next full frame; ends at frame position k=15.
    task automatic scan_frame(output logic [3:0][3:0] an_o, output logic [3:0][6:0] seg_o, output bit ok);
        an_o = '0;
        seg_o = '0;
        sync_frame(ok);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (k % 4 == 1) begin
                an_o[k/4]  = anode_en;
                seg_o[k/4] = seg;
            end
        end
    endtask

    task automatic test_reset();
        int first_fs;
        bit ok;
        @(negedge clk);
        checks++; if (anode_en !== 4'b1111) begin errors++; $display("FAIL reset_anode got=%b exp=1111", anode_en); end
        checks++; if (seg !== OFF_P) begin errors++; $display("FAIL reset_seg got=%b exp=%b", seg, OFF_P); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        reset = 1'b0;
        first_fs = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (anode_en !== 4'b1110 || seg !== DASH_P) begin
                    errors++; $display("FAIL first_slot got=%b/%b exp=1110/%b", anode_en, seg, DASH_P);
                end
            end
            if (frame_start === 1'b1) begin
                first_fs = i;
                break;
            end
        end
        checks++; if (first_fs != 16) begin errors++; $display("FAIL first_frame_start got=%0d exp=16", first_fs); end
        // 32 clocks of scanning from the frame boundary: dashes on every digit.
        for (int k = 0; k < 32; k++) begin
            logic [3:0] exp_an;
            if (k > 0) @(negedge clk);
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            checks++; if (anode_en !== exp_an) begin errors++; $display("FAIL scan_anode k=%0d got=%b exp=%b", k, anode_en, exp_an); end
            checks++; if (seg !== DASH_P) begin errors++; $display("FAIL scan_seg k=%0d got=%b exp=%b", k, seg, DASH_P); end
            checks++; if (frame_start !== (k % 16 == 0)) begin errors++; $display("FAIL scan_fs k=%0d got=%b exp=%b", k, frame_start, (k % 16 == 0)); end
        end
        ok = 1'b1;
        checks++; if (!ok) begin errors++; $display("FAIL scan_done got=0 exp=1"); end
    endtask

    task automatic test_pattern_mole();
        bit ok, fs_ok;
        logic [27:0] pat;
        logic [3:0][6:0] exp_seg;
        pat = {7'b1000000, 7'b1011100, 7'b1000000, 7'b1000000};
        exp_seg = {DASH_P, 7'b0100011, DASH_P, DASH_P};
        sync_frame(fs_ok);
        repeat (2) @(negedge clk);
        send_frame(1'b0, pat, 16'h0000, 4'b0000, 1'b1, ok);
        checks++; if (!(ok && fs_ok)) begin errors++; $display("FAIL mole_send got=%b exp=1", ok && fs_ok); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL mole_ready_low got=%b exp=0", wr_ready); end
        fs_ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                fs_ok = 1'b1;
                break;
            end
            if (anode_en === 4'b1011) begin
                checks++;
                if (seg !== DASH_P) begin errors++; $display("FAIL mole_early got=%b exp=%b", seg, DASH_P); end
            end
        end
        checks++; if (!fs_ok) begin errors++; $display("FAIL mole_commit_timeout got=0 exp=1"); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL mole_ready_back got=%b exp=1", wr_ready); end
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (k % 4 == 1) begin
                checks++;
                if (anode_en !== ~(4'b0001 << (k / 4)) || seg !== exp_seg[k/4]) begin
                    errors++; $display("FAIL mole_digit%0d got=%b/%b exp=%b/%b", k / 4, anode_en, seg, ~(4'b0001 << (k / 4)), exp_seg[k/4]);
                end
            end
        end
    endtask

    task automatic test_hex();
        logic [15:0] nib_t [7];
        logic        lzs_t [7];
        logic [3:0]  blank_t [7];
        logic [3:0]  lit_t [7];
        logic [27:0] seg_t [7];
        logic [3:0][3:0] an_o;
        logic [3:0][6:0] seg_o;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        bit ok1, ok2, ok3;
        nib_t   = '{16'h0045, 16'h0000, 16'h00C0, 16'hAB9F, 16'h1236, 16'h78DE, 16'h0900};
        lzs_t   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        blank_t = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        lit_t   = '{4'b0011, 4'b0001, 4'b0011, 4'b1101, 4'b1111, 4'b1111, 4'b1111};
        seg_t   = '{{OFF_P, OFF_P, 7'b0011001, 7'b0010010},
                    {OFF_P, OFF_P, OFF_P, 7'b1000000},
                    {OFF_P, OFF_P, 7'b1000110, 7'b1000000},
                    {7'b0001000, 7'b0000011, OFF_P, 7'b0001110},
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0000010},
                    {7'b1111000, 7'b0000000, 7'b0100001, 7'b0000110},
                    {7'b1000000, 7'b0010000, 7'b1000000, 7'b1000000}};
        for (int v = 0; v < 7; v++) begin
            sync_frame(ok1);
            repeat (2) @(negedge clk);
            send_frame(1'b1, 28'hFFFFFFF, nib_t[v], blank_t[v], lzs_t[v], ok2);
            scan_frame(an_o, seg_o, ok3);
            checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL hex%0d_timeout got=0 exp=1", v); end
            for (int d = 0; d < 4; d++) begin
                exp_an  = lit_t[v][d] ? ~(4'b0001 << d) : 4'b1111;
                exp_seg = seg_t[v][7*d +: 7];
                checks++; if (an_o[d] !== exp_an) begin errors++; $display("FAIL hex%0d_an%0d got=%b exp=%b", v, d, an_o[d], exp_an); end
                checks++; if (seg_o[d] !== exp_seg) begin errors++; $display("FAIL hex%0d_seg%0d got=%b exp=%b", v, d, seg_o[d], exp_seg); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [27:0] pat_a, pat_b;
        logic [3:0][3:0] an_o, exp_an;
        logic [3:0][6:0] seg_o, exp_seg;
        bit ok1, ok2, ok3;
        int waited;
        pat_a = {4{7'b0001000}};
        pat_b = {7'b1110110, 7'b0111000, 7'b0000110, 7'b1111001};
        exp_an = {4'b1111, 4'b1011, 4'b1101, 4'b1110};
        exp_seg = {OFF_P, 7'b1000111, 7'b1111001, 7'b0000110};
        sync_frame(ok1);
        repeat (2) @(negedge clk);
        send_frame(1'b0, pat_a, 16'h0000, 4'b0000, 1'b1, ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_send_a got=0 exp=1"); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low got=%b exp=0", wr_ready); end
        wr_mode = 1'b0; wr_pattern = pat_b; wr_nibble = 16'h0000; wr_blank = 4'b1000; wr_lzs = 1'b0;
        wr_valid = 1'b1;
        waited = 0;
        while (wr_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (waited != 13) begin errors++; $display("FAIL b2b_hold_cycles got=%0d exp=13", waited); end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_commit got=%b exp=1", frame_start); end
        checks++; if (anode_en !== 4'b1110 || seg !== 7'b1110111) begin
            errors++; $display("FAIL b2b_a_digit0 got=%b/%b exp=1110/1110111", anode_en, seg);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_b_taken got=%b exp=0", wr_ready); end
        for (int k = 2; k < 16; k++) begin
            @(negedge clk);
            checks++; if (seg !== 7'b1110111) begin errors++; $display("FAIL b2b_a_hold k=%0d got=%b exp=1110111", k, seg); end
        end
        scan_frame(an_o, seg_o, ok3);
        checks++; if (!ok3) begin errors++; $display("FAIL b2b_b_timeout got=0 exp=1"); end
        checks++; if (an_o !== exp_an) begin errors++; $display("FAIL b2b_b_anodes got=%h exp=%h", an_o, exp_an); end
        checks++; if (seg_o !== exp_seg) begin errors++; $display("FAIL b2b_b_segs got=%h exp=%h", seg_o, exp_seg); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_end got=%b exp=1", wr_ready); end
    endtask

    task automatic test_wrap_offer();
        logic [3:0][3:0] an_o;
        logic [3:0][6:0] seg_o, exp_seg;
        bit ok1, ok2;
        exp_seg = {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        sync_frame(ok1);
        repeat (15) @(negedge clk);
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready_pre got=%b exp=1", wr_ready); end
        wr_mode = 1'b1; wr_pattern = '0; wr_nibble = 16'h4321; wr_blank = 4'b0000; wr_lzs = 1'b0;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL wrap_coincide got=%b exp=1", frame_start); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL wrap_captured got=%b exp=0", wr_ready); end
        checks++; if (anode_en !== 4'b1110 || seg !== 7'b0000110) begin
            errors++; $display("FAIL wrap_old_digit0 got=%b/%b exp=1110/0000110", anode_en, seg);
        end
        scan_frame(an_o, seg_o, ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL wrap_timeout got=0 exp=1"); end
        checks++; if (an_o !== {4'b0111, 4'b1011, 4'b1101, 4'b1110}) begin errors++; $display("FAIL wrap_anodes got=%h exp=7bde", an_o); end
        checks++; if (seg_o !== exp_seg) begin errors++; $display("FAIL wrap_segs got=%h exp=%h", seg_o, exp_seg); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready_end got=%b exp=1", wr_ready); end
    endtask

    task automatic test_reset_mid();
        logic [3:0][3:0] an_o;
        logic [3:0][6:0] seg_o;
        bit ok1, ok2;
        sync_frame(ok1);
        repeat (2) @(negedge clk);
        send_frame(1'b1, '0, 16'h8888, 4'b0000, 1'b0, ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL rmid_send got=0 exp=1"); end
        repeat (3) @(negedge clk);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rmid_pending got=%b exp=0", wr_ready); end
        reset = 1'b1;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b exp=1", wr_ready); end
        checks++; if (anode_en !== 4'b1111 || seg !== OFF_P) begin errors++; $display("FAIL rmid_dark got=%b/%b exp=1111/%b", anode_en, seg, OFF_P); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rmid_fs got=%b exp=0", frame_start); end
        @(negedge clk);
        reset = 1'b0;
        for (int f = 0; f < 2; f++) begin
            scan_frame(an_o, seg_o, ok1);
            checks++; if (!ok1) begin errors++; $display("FAIL rmid_timeout%0d got=0 exp=1", f); end
            checks++; if (an_o !== {4'b0111, 4'b1011, 4'b1101, 4'b1110}) begin errors++; $display("FAIL rmid_anodes%0d got=%h exp=7bde", f, an_o); end
            checks++; if (seg_o !== {4{DASH_P}}) begin errors++; $display("FAIL rmid_segs%0d got=%h exp=%h", f, seg_o, {4{DASH_P}}); end
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after%0d got=%b exp=1", f, wr_ready); end
        end
    endtask

`ifdef SEVSEG_BLINK_EN
    task automatic test_blink();
        bit ok;
        bit lit;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wr_blink = 4'b0001;
        send_frame(1'b0, {4{7'b1000000}}, 16'h0000, 4'b0000, 1'b0, ok);
        wr_blink = 4'b0000;
        checks++; if (!ok) begin errors++; $display("FAIL blink_send got=0 exp=1"); end
        // Frame j's digit-0 slot sits at blink count 16j, so bit 5 is set for j mod 4 in {2,3}.
        for (int j = 1; j <= 8; j++) begin
            sync_frame(ok);
            lit = (j % 4 == 0) || (j % 4 == 1);
            checks++; if (!ok) begin errors++; $display("FAIL blink_timeout%0d got=0 exp=1", j); end
            checks++; if (anode_en !== (lit ? 4'b1110 : 4'b1111) || seg !== (lit ? DASH_P : OFF_P)) begin
                errors++; $display("FAIL blink_d0_f%0d got=%b/%b exp_lit=%b", j, anode_en, seg, lit);
            end
            repeat (5) @(negedge clk);
            checks++; if (anode_en !== 4'b1101 || seg !== DASH_P) begin
                errors++; $display("FAIL blink_d1_f%0d got=%b/%b exp=1101/%b", j, anode_en, seg, DASH_P);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pattern_mole();
        test_hex();
        test_back_to_back();
        test_wrap_offer();
        test_reset_mid();
`ifdef SEVSEG_BLINK_EN
        test_blink();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
